// File: rtl/duck_vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : duck_vga_pkg
//  Description : Shared VGA timing constants, colour/state/sprite types for the
//                sprite layer scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package duck_vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int COORD_W  = 10;

    typedef logic [5:0] color_t;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        VBLANK     = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } sprite_pos_t;

endpackage
`default_nettype wire

// File: rtl/sprite_hit_test.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_hit_test
//  Description : Bounding-box test of one sprite against the current pixel,
//                plus the sprite-local row/column offsets.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_hit_test
    import duck_vga_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32
) (
    input  sprite_pos_t                   pos_i,
    input  logic [9:0]                    hor_i,
    input  logic [9:0]                    ver_i,
    output logic                          hit_o,
    output logic [$clog2(SPRITE_H)-1:0]   row_o,
    output logic [$clog2(SPRITE_W)-1:0]   col_o
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);

    logic [10:0] w_h;
    logic [10:0] w_v;
    logic [10:0] w_x0;
    logic [10:0] w_y0;
    logic [10:0] w_x1;
    logic [10:0] w_y1;

    // 11-bit compare so a sprite near the right/bottom edge never wraps to column 0
    assign w_h  = {1'b0, hor_i};
    assign w_v  = {1'b0, ver_i};
    assign w_x0 = {1'b0, pos_i.x};
    assign w_y0 = {1'b0, pos_i.y};
    assign w_x1 = w_x0 + 11'(SPRITE_W);
    assign w_y1 = w_y0 + 11'(SPRITE_H);

    assign hit_o = pos_i.en && (w_h >= w_x0) && (w_h < w_x1)
                            && (w_v >= w_y0) && (w_v < w_y1);
    assign col_o = CW'(hor_i - pos_i.x);
    assign row_o = RW'(ver_i - pos_i.y);

endmodule
`default_nettype wire

// File: rtl/sprite_layer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_layer_scheduler
//  Description : Per-pixel priority arbitration of NUM_SPRITES sprites onto one
//                bitmap ROM port; vblank-only position updates, 2-cycle latency.
//                Optional macro COLLISION_DETECT_EN adds a sticky collision flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_layer_scheduler
    import duck_vga_pkg::*;
#(
    parameter int         NUM_SPRITES = 4,
    parameter int         SPRITE_W    = 32,
    parameter int         SPRITE_H    = 32,
    parameter int         H_ACTIVE    = 640,
    parameter int         V_ACTIVE    = 480,
    parameter logic [5:0] TRANSP      = 6'h3F,
    parameter int         ROM_AW      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        hor_count,
    input  logic [9:0]        ver_count,
    input  logic [5:0]        bg_color,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [1:0]        upd_idx,
    input  logic [9:0]        upd_x,
    input  logic [9:0]        upd_y,
    input  logic              upd_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [5:0]        rom_data,
    output logic [5:0]        rgb_out,
    output logic              sprite_hit,
`ifdef COLLISION_DETECT_EN
    output logic              collision,
`endif
    output logic              frame_start
);

    localparam int          IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int          CW    = $clog2(SPRITE_W);
    localparam int          RW    = $clog2(SPRITE_H);
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

    sched_state_t           state_q;
    sched_state_t           state_d;
    sprite_pos_t            shadow_q [NUM_SPRITES];
    sprite_pos_t            active_q [NUM_SPRITES];
    sprite_pos_t            w_pos    [NUM_SPRITES];
    logic [RW-1:0]          w_row    [NUM_SPRITES];
    logic [CW-1:0]          w_col    [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] w_hit;

    logic                   w_frame_start;
    logic                   w_commit;
    logic                   w_xfer;
    logic                   w_visible;
    logic                   w_any_hit;
    logic [IDX_W-1:0]       w_sel;
    logic [RW-1:0]          w_row_sel;
    logic [CW-1:0]          w_col_sel;
    logic                   w_sprite_px;
    logic [ROM_AW-1:0]      rom_addr_d;

    logic                   hit_q;
    logic                   visible_q;
    logic [5:0]             bg_q;
    logic [ROM_AW-1:0]      rom_addr_q;
    logic [5:0]             rgb_q;
    logic                   sprite_hit_q;
    logic                   frame_start_q;

    assign w_frame_start = (hor_count == 10'd0) && (ver_count == 10'd0);
    assign w_visible     = ({1'b0, hor_count} < H_LIM) && ({1'b0, ver_count} < V_LIM);
    assign w_xfer        = upd_valid && upd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WAIT_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FRAME: if (w_frame_start)                  state_d = ACTIVE;
            ACTIVE:     if ({1'b0, ver_count} == V_LIM)     state_d = VBLANK;
            VBLANK:     if (w_frame_start)                  state_d = ACTIVE;
            default:                                        state_d = WAIT_FRAME;
        endcase
    end

    // Frame start blocks the handshake, so a shadow write never races the commit
    always_comb begin
        upd_ready = (state_q == VBLANK) && !w_frame_start;
        w_commit  = (state_q != ACTIVE) && w_frame_start;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (w_xfer && (upd_idx == 2'(i))) begin
                    shadow_q[i] <= {upd_en, upd_x, upd_y};
                end
                if (w_commit) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sprite
            // Pixel (0,0) already sees the positions being committed on that cycle
            assign w_pos[g] = w_commit ? shadow_q[g] : active_q[g];

            sprite_hit_test #(
                .SPRITE_W (SPRITE_W),
                .SPRITE_H (SPRITE_H)
            ) u_hit (
                .pos_i (w_pos[g]),
                .hor_i (hor_count),
                .ver_i (ver_count),
                .hit_o (w_hit[g]),
                .row_o (w_row[g]),
                .col_o (w_col[g])
            );
        end
    endgenerate

    always_comb begin
        w_sel     = '0;
        w_row_sel = '0;
        w_col_sel = '0;
        w_any_hit = 1'b0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel     = IDX_W'(i);
                w_row_sel = w_row[i];
                w_col_sel = w_col[i];
                w_any_hit = 1'b1;
            end
        end
        w_any_hit  = w_any_hit && w_visible;
        rom_addr_d = w_any_hit ? ROM_AW'({w_sel, w_row_sel, w_col_sel}) : '0;
    end

    assign w_sprite_px = hit_q && (rom_data != TRANSP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q         <= 1'b0;
            visible_q     <= 1'b0;
            bg_q          <= '0;
            rom_addr_q    <= '0;
            rgb_q         <= '0;
            sprite_hit_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hit_q         <= w_any_hit;
            visible_q     <= w_visible;
            bg_q          <= bg_color;
            rom_addr_q    <= rom_addr_d;
            sprite_hit_q  <= w_sprite_px;
            rgb_q         <= w_sprite_px ? rom_data : (visible_q ? bg_q : 6'd0);
            frame_start_q <= w_commit;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign rgb_out     = rgb_q;
    assign sprite_hit  = sprite_hit_q;
    assign frame_start = frame_start_q;

`ifdef COLLISION_DETECT_EN
    logic collision_q;
    logic w_coll;

    assign w_coll = w_visible && w_hit[0] && (|w_hit[NUM_SPRITES-1:1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collision_q <= 1'b0;
        end else if (w_commit) begin
            collision_q <= 1'b0;
        end else if (w_coll) begin
            collision_q <= 1'b1;
        end
    end

    assign collision = collision_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_layer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_layer_scheduler
//  Description : Directed self-checking bench; coordinates are driven directly
//                to jump between frame start, active pixels and vblank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_layer_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hor_count;
    logic [9:0]  ver_count;
    logic [5:0]  bg_color;
    logic        upd_valid;
    logic        upd_ready;
    logic [1:0]  upd_idx;
    logic [9:0]  upd_x;
    logic [9:0]  upd_y;
    logic        upd_en;
    logic [11:0] rom_addr;
    logic [5:0]  rom_data;
    logic [5:0]  rgb_out;
    logic        sprite_hit;
    logic        frame_start;
`ifdef COLLISION_DETECT_EN
    logic        collision;
`endif

    logic        transp_en;
    logic [11:0] transp_addr;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    sprite_layer_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hor_count   (hor_count),
        .ver_count   (ver_count),
        .bg_color    (bg_color),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_idx     (upd_idx),
        .upd_x       (upd_x),
        .upd_y       (upd_y),
        .upd_en      (upd_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rgb_out     (rgb_out),
        .sprite_hit  (sprite_hit),
`ifdef COLLISION_DETECT_EN
        .collision   (collision),
`endif
        .frame_start (frame_start)
    );

    // Asynchronous-read ROM model; its top bit is always 0 so it never yields 6'h3F by itself
    function automatic logic [5:0] rom_fn(input logic [11:0] a);
        return {1'b0, a[4:0] ^ {a[11:10], 3'b000}};
    endfunction

    assign rom_data = (transp_en && rom_addr == transp_addr) ? 6'h3F : rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic [5:0] bg);
        hor_count = h;
        ver_count = v;
        bg_color  = bg;
    endtask

    task automatic probe(input string tag, input logic [9:0] h, input logic [9:0] v,
                         input logic [5:0] bg, input logic chk_addr, input logic [11:0] exp_addr,
                         input logic exp_hit, input logic [5:0] exp_rgb);
        drive(h, v, bg);
        tick();
        if (chk_addr) chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
        tick();
        chk({tag, ".hit"}, 32'(sprite_hit), 32'(exp_hit));
        chk({tag, ".rgb"}, 32'(rgb_out), 32'(exp_rgb));
    endtask

    task automatic new_frame(input string tag);
        drive(10'd0, 10'd0, 6'd0);
        tick();
        chk({tag, ".fs"}, 32'(frame_start), 32'd1);
        drive(10'd1, 10'd0, 6'd0);
        tick();
        chk({tag, ".fs_end"}, 32'(frame_start), 32'd0);
    endtask

    task automatic enter_vblank(input string tag);
        drive(10'd0, 10'd480, 6'd0);
        tick();
        drive(10'd3, 10'd490, 6'd0);
        #1;
        chk({tag, ".vb_ready"}, 32'(upd_ready), 32'd1);
    endtask

    task automatic write_upd(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y,
                             input logic en);
        upd_idx   = idx;
        upd_x     = x;
        upd_y     = y;
        upd_en    = en;
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        upd_valid   = 1'b0;
        upd_idx     = '0;
        upd_x       = '0;
        upd_y       = '0;
        upd_en      = 1'b0;
        transp_en   = 1'b0;
        transp_addr = '0;
        drive(10'd5, 10'd5, 6'h15);
        repeat (3) tick();

        chk("rst.rgb",   32'(rgb_out),     32'd0);
        chk("rst.hit",   32'(sprite_hit),  32'd0);
        chk("rst.addr",  32'(rom_addr),    32'd0);
        chk("rst.ready", 32'(upd_ready),   32'd0);
        chk("rst.fs",    32'(frame_start), 32'd0);
`ifdef COLLISION_DETECT_EN
        chk("rst.coll",  32'(collision),   32'd0);
`endif

        // 1: empty frame shows delayed background only
        rst_n = 1'b1;
        drive(10'd10, 10'd10, 6'd0);
        #1;
        chk("t1.ready_wait", 32'(upd_ready), 32'd0);
        tick();
        new_frame("t1");
        probe("t1.a", 10'd1,   10'd0,   6'h12, 1'b0, 12'd0, 1'b0, 6'h12);
        probe("t1.b", 10'd300, 10'd200, 6'h2A, 1'b0, 12'd0, 1'b0, 6'h2A);
        probe("t1.c", 10'd639, 10'd479, 6'h05, 1'b0, 12'd0, 1'b0, 6'h05);
        drive(10'd10, 10'd479, 6'd0);
        #1;
        chk("t1.ready_479", 32'(upd_ready), 32'd0);
        tick();
        enter_vblank("t1");
        probe("t1.vblank", 10'd5, 10'd480, 6'h11, 1'b0, 12'd0, 1'b0, 6'h00);

        // 2: slot 1 at (100,50)
        write_upd(2'd1, 10'd100, 10'd50, 1'b1);
        new_frame("t2");
        probe("t2.tl",   10'd100, 10'd50, 6'h01, 1'b1, 12'h400, 1'b1, 6'h08);
        probe("t2.br",   10'd131, 10'd81, 6'h01, 1'b1, 12'h7FF, 1'b1, 6'h17);
        probe("t2.right",10'd132, 10'd50, 6'h22, 1'b0, 12'd0,   1'b0, 6'h22);
        probe("t2.left", 10'd99,  10'd50, 6'h23, 1'b0, 12'd0,   1'b0, 6'h23);

        // 3: slot 0 wins over slot 2; a transparent slot-0 pixel shows background
        enter_vblank("t3");
        write_upd(2'd0, 10'd190, 10'd190, 1'b1);
        write_upd(2'd2, 10'd195, 10'd195, 1'b1);
        new_frame("t3");
        probe("t3.prio", 10'd200, 10'd200, 6'h2C, 1'b1, 12'h14A, 1'b1, 6'h0A);
        probe("t3.s2",   10'd224, 10'd224, 6'h2C, 1'b1, 12'hBBD, 1'b1, 6'h0D);
        transp_en   = 1'b1;
        transp_addr = 12'h14A;
        probe("t3.transp", 10'd200, 10'd200, 6'h2C, 1'b1, 12'h14A, 1'b0, 6'h2C);
        transp_en   = 1'b0;

        // 4: update held through active video, then last write wins
        drive(10'd50, 10'd100, 6'd0);
        upd_idx   = 2'd3;
        upd_x     = 10'd400;
        upd_y     = 10'd400;
        upd_en    = 1'b1;
        upd_valid = 1'b1;
        #1;
        chk("t4.ready_act0", 32'(upd_ready), 32'd0);
        tick();
        chk("t4.ready_act1", 32'(upd_ready), 32'd0);
        drive(10'd0, 10'd480, 6'd0);
        tick();
        chk("t4.ready_vb", 32'(upd_ready), 32'd1);
        tick();
        upd_x = 10'd500;
        upd_y = 10'd300;
        tick();
        upd_valid = 1'b0;
        new_frame("t4");
        probe("t4.first",  10'd400, 10'd400, 6'h33, 1'b0, 12'd0,   1'b0, 6'h33);
        probe("t4.second", 10'd500, 10'd300, 6'h33, 1'b1, 12'hC00, 1'b1, 6'h18);

        // 5: right-edge clipping, then reset mid-frame
        enter_vblank("t5");
        write_upd(2'd1, 10'd620, 10'd100, 1'b1);
        new_frame("t5");
        probe("t5.x620", 10'd620, 10'd100, 6'h21, 1'b1, 12'h400, 1'b1, 6'h08);
        probe("t5.x639", 10'd639, 10'd100, 6'h21, 1'b1, 12'h413, 1'b1, 6'h1B);
        probe("t5.x640", 10'd640, 10'd100, 6'h21, 1'b0, 12'd0,   1'b0, 6'h00);
        probe("t5.pre",  10'd639, 10'd100, 6'h21, 1'b0, 12'd0,   1'b1, 6'h1B);
        drive(10'd625, 10'd240, 6'h2B);
        rst_n = 1'b0;
        tick();
        chk("t5.rst_rgb",   32'(rgb_out),     32'd0);
        chk("t5.rst_hit",   32'(sprite_hit),  32'd0);
        chk("t5.rst_addr",  32'(rom_addr),    32'd0);
        chk("t5.rst_fs",    32'(frame_start), 32'd0);
        chk("t5.rst_ready", 32'(upd_ready),   32'd0);
        rst_n = 1'b1;
        probe("t5.wait",  10'd625, 10'd105, 6'h1E, 1'b0, 12'd0, 1'b0, 6'h1E);
        new_frame("t5r");
        probe("t5.after", 10'd625, 10'd105, 6'h1D, 1'b0, 12'd0, 1'b0, 6'h1D);

`ifdef COLLISION_DETECT_EN
        // 6: sticky collision flag, cleared at the next commit
        chk("t6.coll_init", 32'(collision), 32'd0);
        enter_vblank("t6");
        write_upd(2'd0, 10'd300, 10'd300, 1'b1);
        write_upd(2'd1, 10'd310, 10'd310, 1'b1);
        new_frame("t6");
        chk("t6.coll_fs", 32'(collision), 32'd0);
        drive(10'd315, 10'd315, 6'd0);
        tick();
        chk("t6.coll_set", 32'(collision), 32'd1);
        drive(10'd10, 10'd10, 6'd0);
        tick();
        chk("t6.coll_sticky", 32'(collision), 32'd1);
        enter_vblank("t6b");
        write_upd(2'd1, 10'd0, 10'd0, 1'b1);
        drive(10'd0, 10'd0, 6'd0);
        tick();
        chk("t6.fs2",       32'(frame_start), 32'd1);
        chk("t6.coll_clr",  32'(collision),   32'd0);
        probe("t6.s0", 10'd315, 10'd315, 6'h01, 1'b1, 12'h1EF, 1'b1, 6'h0F);
        chk("t6.coll_s0",   32'(collision),   32'd0);
        probe("t6.s1", 10'd5,   10'd5,   6'h01, 1'b1, 12'h4A5, 1'b1, 6'h0D);
        chk("t6.coll_s1",   32'(collision),   32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
